// File: rtl/stack_warning_mc.sv
// Multi-channel idle-frame watchdog: per-channel saturating idle counters with sticky
// warning/alarm flags and a longest-idle channel index. Optional irq via STACK_WARN_IRQ_EN.
module stack_warning_mc #(
  parameter int NCH      = 4,
  parameter int CNT_W    = 11,
  parameter int WARN_TH  = 100,
  parameter int ALARM_TH = 200,
  localparam int MW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       valid_in,
  input  logic [NCH-1:0]       data_in,
  input  logic [NCH-1:0]       clr,
  output logic [NCH-1:0]       warning,
  output logic [NCH-1:0]       alarm,
  output logic [NCH*CNT_W-1:0] stack,
  output logic                 any_warning,
  output logic                 any_alarm,
  output logic [MW-1:0]        max_ch
`ifdef STACK_WARN_IRQ_EN
  ,
  output logic                 irq,
  input  logic                 irq_ack
`endif
);

  localparam logic [CNT_W-1:0] WARN_V  = CNT_W'(WARN_TH);
  localparam logic [CNT_W-1:0] ALARM_V = CNT_W'(ALARM_TH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0]   prevalid;
  logic [NCH-1:0]   idle_evt;
  logic [NCH-1:0]   kill;
  logic [CNT_W-1:0] cnt [NCH];
  logic [MW-1:0]    best_idx;
  logic [CNT_W-1:0] best_val;

  assign idle_evt = valid_in & ~prevalid & ~data_in;
  // Activity clears for the whole time valid is high, not just on the frame edge.
  assign kill     = clr | (valid_in & data_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      prevalid <= '0;
      warning  <= '0;
      alarm    <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      prevalid <= valid_in;
      for (int i = 0; i < NCH; i++) begin
        if (kill[i]) begin
          cnt[i]     <= '0;
          warning[i] <= 1'b0;
          alarm[i]   <= 1'b0;
        end else begin
          if (idle_evt[i] && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
          // Flags compare the registered count, so they trail the count by one clock.
          if (cnt[i] >= WARN_V)  warning[i] <= 1'b1;
          if (cnt[i] >= ALARM_V) alarm[i]   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    best_idx = '0;
    best_val = cnt[0];
    for (int i = 1; i < NCH; i++) begin
      if (cnt[i] > best_val) begin
        best_val = cnt[i];
        best_idx = MW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) max_ch <= '0;
    else     max_ch <= best_idx;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_stack
    assign stack[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign any_warning = |warning;
  assign any_alarm   = |alarm;

`ifdef STACK_WARN_IRQ_EN
  logic [NCH-1:0] warn_q;
  logic [NCH-1:0] alarm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      warn_q  <= '0;
      alarm_q <= '0;
      irq     <= 1'b0;
    end else begin
      warn_q  <= warning;
      alarm_q <= alarm;
      // A new flag rise beats a simultaneous acknowledge.
      if (|((warning & ~warn_q) | (alarm & ~alarm_q))) irq <= 1'b1;
      else if (irq_ack)                                irq <= 1'b0;
    end
  end
`endif

endmodule
